// File: rtl/mem_stage_dmem_ctrl_pkg.sv
// RV32I load/store encodings, controller state type and small helpers
// shared by the MEM-stage data-memory controller and its load aligner.
package mem_stage_dmem_ctrl_pkg;

   typedef enum logic [2:0] {
      LF_LB  = 3'b000,
      LF_LH  = 3'b001,
      LF_LW  = 3'b010,
      LF_LBU = 3'b100,
      LF_LHU = 3'b101
   } load_funct3_t;

   typedef enum logic [2:0] {
      SF_SB = 3'b000,
      SF_SH = 3'b001,
      SF_SW = 3'b010
   } store_funct3_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_DONE  = 2'd2,
      ST_DRAIN = 2'd3
   } dmem_state_t;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2
   } access_size_t;

   // Undefined funct3 encodings fall back to word width.
   function automatic access_size_t access_size(input logic [2:0] f3, input logic is_load);
      access_size_t sz;
      if (is_load) begin
         case (f3)
            LF_LB, LF_LBU: sz = SZ_B;
            LF_LH, LF_LHU: sz = SZ_H;
            default:       sz = SZ_W;
         endcase
      end else begin
         case (f3)
            SF_SB:   sz = SZ_B;
            SF_SH:   sz = SZ_H;
            default: sz = SZ_W;
         endcase
      end
      return sz;
   endfunction

   function automatic logic is_misaligned(input access_size_t sz, input logic [1:0] off);
      logic mis;
      case (sz)
         SZ_B:    mis = 1'b0;
         SZ_H:    mis = off[0];
         default: mis = (off != 2'b00);
      endcase
      return mis;
   endfunction

   function automatic logic [3:0] store_mbe(input logic [2:0] f3, input logic [1:0] off);
      logic [3:0] mbe;
      case (f3)
         SF_SB:   mbe = 4'b0001 << off;
         SF_SH:   mbe = 4'b0011 << {off[1], 1'b0};
         default: mbe = 4'b1111;
      endcase
      return mbe;
   endfunction

   function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] rs2);
      logic [31:0] wd;
      case (f3)
         SF_SB:   wd = {4{rs2[7:0]}};
         SF_SH:   wd = {2{rs2[15:0]}};
         default: wd = rs2;
      endcase
      return wd;
   endfunction

endpackage

// File: rtl/mem_stage_dmem_ctrl_if.sv
// Data-memory request/response port: the controller is the master,
// the memory the slave.
interface mem_stage_dmem_ctrl_if;
   logic        dmem_read;
   logic        dmem_write;
   logic [3:0]  dmem_mbe;
   logic [31:0] dmem_address;
   logic [31:0] dmem_wdata;
   logic        dmem_resp;
   logic [31:0] dmem_rdata;

   modport master (
      output dmem_read, dmem_write, dmem_mbe, dmem_address, dmem_wdata,
      input  dmem_resp, dmem_rdata
   );

   modport slave (
      input  dmem_read, dmem_write, dmem_mbe, dmem_address, dmem_wdata,
      output dmem_resp, dmem_rdata
   );
endinterface

// File: rtl/mem_stage_dmem_ctrl_load_align_ext.sv
// Combinational byte/half select and sign/zero extension of a loaded word;
// kept separate so the forwarding path can reuse it.
module mem_stage_dmem_ctrl_load_align_ext
   import mem_stage_dmem_ctrl_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  offset,
   input  logic [31:0] rdata,
   output logic [31:0] data
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   assign byte_s = rdata[{offset, 3'b000} +: 8];
   assign half_s = rdata[{offset[1], 4'b0000} +: 16];

   // Extend the selected lane according to the load type.
   always_comb begin
      data = 32'h0000_0000;
      case (funct3)
         LF_LB:   data = {{24{byte_s[7]}}, byte_s};
         LF_LBU:  data = {24'h00_0000, byte_s};
         LF_LH:   data = {{16{half_s[15]}}, half_s};
         LF_LHU:  data = {16'h0000, half_s};
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_stage_dmem_ctrl.sv
// MEM-stage data-memory controller: issues loads/stores, stalls the pipeline
// until the access completes and holds the load result until MEM/WB loads it.
module mem_stage_dmem_ctrl
   import mem_stage_dmem_ctrl_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  valid_i,
   input  logic                  mem_read_i,
   input  logic                  mem_write_i,
   input  logic [2:0]            funct3_i,
   input  logic [31:0]           alu_out_i,
   input  logic [31:0]           rs2_out_i,
   input  logic                  advance_i,
   input  logic                  flush_i,
   mem_stage_dmem_ctrl_if.master dmem,
   output logic [31:0]           load_data_o,
   output logic                  stall_o,
   output logic                  misaligned_o
);

   dmem_state_t state_r;
   logic        req_read_r, req_write_r;
   logic [3:0]  req_mbe_r;
   logic [31:0] req_addr_r, req_wdata_r;
   logic [2:0]  req_funct3_r;
   logic [1:0]  req_off_r;
   logic [31:0] load_data_r;
   logic        misaligned_r;

   logic        op_s, mis_s;
   logic        read_s, write_s, stall_s;
   logic [3:0]  mbe_s;
   logic [31:0] addr_s, wdata_s;
   logic [2:0]  cur_funct3_s;
   logic [1:0]  cur_off_s;
   logic [31:0] ext_data_s;

   assign op_s = valid_i & (mem_read_i | mem_write_i) & ~flush_i;
   assign mis_s = is_misaligned(access_size(funct3_i, mem_read_i), alu_out_i[1:0]);

   // The aligner sees the live instruction in IDLE and the latched one afterwards.
   assign cur_funct3_s = (state_r == ST_IDLE) ? funct3_i : req_funct3_r;
   assign cur_off_s    = (state_r == ST_IDLE) ? alu_out_i[1:0] : req_off_r;

   mem_stage_dmem_ctrl_load_align_ext u_align (
      .funct3 (cur_funct3_s),
      .offset (cur_off_s),
      .rdata  (dmem.dmem_rdata),
      .data   (ext_data_s)
   );

   // Request and stall decode; IDLE issues straight from EX/MEM, REQ/DRAIN replay latched fields.
   always_comb begin
      read_s  = 1'b0;
      write_s = 1'b0;
      mbe_s   = 4'b0000;
      addr_s  = 32'h0000_0000;
      wdata_s = 32'h0000_0000;
      stall_s = 1'b0;
      if (rst) begin
         stall_s = 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               stall_s = op_s;
               if (op_s && !mis_s) begin
                  read_s  = mem_read_i;
                  write_s = mem_write_i;
                  mbe_s   = mem_read_i ? 4'b1111 : store_mbe(funct3_i, alu_out_i[1:0]);
                  addr_s  = {alu_out_i[31:2], 2'b00};
                  wdata_s = store_wdata(funct3_i, rs2_out_i);
               end else begin
                  read_s = 1'b0;
               end
            end
            ST_REQ, ST_DRAIN: begin
               read_s  = req_read_r;
               write_s = req_write_r;
               mbe_s   = req_mbe_r;
               addr_s  = req_addr_r;
               wdata_s = req_wdata_r;
               stall_s = (state_r == ST_REQ);
            end
            default: stall_s = 1'b0;
         endcase
      end
   end

   assign dmem.dmem_read    = read_s;
   assign dmem.dmem_write   = write_s;
   assign dmem.dmem_mbe     = mbe_s;
   assign dmem.dmem_address = addr_s;
   assign dmem.dmem_wdata   = wdata_s;
   assign stall_o           = stall_s;
   assign load_data_o       = load_data_r;
   assign misaligned_o      = misaligned_r;

   // Controller FSM with latched request fields and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         req_read_r   <= 1'b0;
         req_write_r  <= 1'b0;
         req_mbe_r    <= 4'b0000;
         req_addr_r   <= 32'h0000_0000;
         req_wdata_r  <= 32'h0000_0000;
         req_funct3_r <= 3'b000;
         req_off_r    <= 2'b00;
         load_data_r  <= 32'h0000_0000;
         misaligned_r <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (op_s && mis_s) begin
                  misaligned_r <= 1'b1;
                  load_data_r  <= 32'h0000_0000;
                  state_r      <= ST_DONE;
               end else if (op_s) begin
                  req_read_r   <= read_s;
                  req_write_r  <= write_s;
                  req_mbe_r    <= mbe_s;
                  req_addr_r   <= addr_s;
                  req_wdata_r  <= wdata_s;
                  req_funct3_r <= funct3_i;
                  req_off_r    <= alu_out_i[1:0];
                  if (dmem.dmem_resp) begin
                     load_data_r <= mem_read_i ? ext_data_s : 32'h0000_0000;
                     state_r     <= ST_DONE;
                  end else begin
                     state_r <= ST_REQ;
                  end
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_REQ: begin
               // A squashed access still runs to completion; only its result is dropped.
               if (dmem.dmem_resp && flush_i) begin
                  state_r <= ST_IDLE;
               end else if (dmem.dmem_resp) begin
                  load_data_r <= req_read_r ? ext_data_s : 32'h0000_0000;
                  state_r     <= ST_DONE;
               end else if (flush_i) begin
                  state_r <= ST_DRAIN;
               end else begin
                  state_r <= ST_REQ;
               end
            end
            ST_DRAIN: begin
               if (dmem.dmem_resp) begin
                  state_r <= ST_IDLE;
               end else begin
                  state_r <= ST_DRAIN;
               end
            end
            ST_DONE: begin
               if (advance_i || flush_i) begin
                  load_data_r  <= 32'h0000_0000;
                  misaligned_r <= 1'b0;
                  state_r      <= ST_IDLE;
               end else begin
                  state_r <= ST_DONE;
               end
            end
            default: state_r <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage_dmem_ctrl.sv
// Directed self-checking bench for mem_stage_dmem_ctrl.
module tb_mem_stage_dmem_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_i, mem_read_i, mem_write_i, advance_i, flush_i;
   logic [2:0]  funct3_i;
   logic [31:0] alu_out_i, rs2_out_i;
   logic [31:0] load_data_o;
   logic        stall_o, misaligned_o;

   int errors = 0;
   int checks = 0;
   int pulses;

   mem_stage_dmem_ctrl_if dmem_bus ();

   mem_stage_dmem_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .valid_i      (valid_i),
      .mem_read_i   (mem_read_i),
      .mem_write_i  (mem_write_i),
      .funct3_i     (funct3_i),
      .alu_out_i    (alu_out_i),
      .rs2_out_i    (rs2_out_i),
      .advance_i    (advance_i),
      .flush_i      (flush_i),
      .dmem         (dmem_bus.master),
      .load_data_o  (load_data_o),
      .stall_o      (stall_o),
      .misaligned_o (misaligned_o)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic clear_inputs();
      valid_i     = 1'b0;
      mem_read_i  = 1'b0;
      mem_write_i = 1'b0;
      funct3_i    = 3'b000;
      alu_out_i   = 32'h0000_0000;
      rs2_out_i   = 32'h0000_0000;
      advance_i   = 1'b0;
      flush_i     = 1'b0;
      dmem_bus.dmem_resp  = 1'b0;
      dmem_bus.dmem_rdata = 32'h0000_0000;
   endtask

   task automatic drive_op(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] rs2);
      valid_i     = 1'b1;
      mem_read_i  = rd;
      mem_write_i = wr;
      funct3_i    = f3;
      alu_out_i   = addr;
      rs2_out_i   = rs2;
   endtask

   // DONE -> IDLE with the next slot empty.
   task automatic retire();
      clear_inputs();
      advance_i = 1'b1;
      tick();
      advance_i = 1'b0;
   endtask

   // Single-cycle access: response in the request cycle, result checked in DONE.
   task automatic quick_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] rdata, input logic [31:0] exp);
      drive_op(1'b1, 1'b0, f3, addr, 32'h0000_0000);
      dmem_bus.dmem_resp  = 1'b1;
      dmem_bus.dmem_rdata = rdata;
      settle();
      check_eq({tag, "_read"}, {31'd0, dmem_bus.dmem_read}, 32'd1);
      tick();
      dmem_bus.dmem_resp = 1'b0;
      settle();
      check_eq({tag, "_data"}, load_data_o, exp);
      retire();
   endtask

   task automatic quick_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] rs2, input logic [3:0] exp_mbe,
                              input logic [31:0] exp_wdata);
      drive_op(1'b0, 1'b1, f3, addr, rs2);
      dmem_bus.dmem_resp = 1'b1;
      settle();
      check_eq({tag, "_write"}, {31'd0, dmem_bus.dmem_write}, 32'd1);
      check_eq({tag, "_mbe"}, {28'd0, dmem_bus.dmem_mbe}, {28'd0, exp_mbe});
      check_eq({tag, "_wdata"}, dmem_bus.dmem_wdata, exp_wdata);
      check_eq({tag, "_addr"}, dmem_bus.dmem_address, {addr[31:2], 2'b00});
      tick();
      dmem_bus.dmem_resp = 1'b0;
      retire();
   endtask

   initial begin
      clear_inputs();
      rst = 1'b1;
      tick();
      tick();
      settle();
      check_eq("rst_read", {31'd0, dmem_bus.dmem_read}, 32'd0);
      check_eq("rst_stall", {31'd0, stall_o}, 32'd0);
      check_eq("rst_data", load_data_o, 32'd0);
      check_eq("rst_mis", {31'd0, misaligned_o}, 32'd0);
      rst = 1'b0;
      tick();

      // 1: lw with three request cycles
      drive_op(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0000_0000);
      for (int i = 0; i < 3; i++) begin
         dmem_bus.dmem_resp  = (i == 2);
         dmem_bus.dmem_rdata = (i == 2) ? 32'hDEAD_BEEF : 32'h0000_0000;
         settle();
         check_eq($sformatf("lw_read%0d", i), {31'd0, dmem_bus.dmem_read}, 32'd1);
         check_eq($sformatf("lw_stall%0d", i), {31'd0, stall_o}, 32'd1);
         check_eq($sformatf("lw_addr%0d", i), dmem_bus.dmem_address, 32'h0000_0100);
         tick();
      end
      dmem_bus.dmem_resp = 1'b0;
      settle();
      check_eq("lw_done_read", {31'd0, dmem_bus.dmem_read}, 32'd0);
      check_eq("lw_done_stall", {31'd0, stall_o}, 32'd0);
      check_eq("lw_data", load_data_o, 32'hDEAD_BEEF);
      retire();
      settle();
      check_eq("lw_cleared", load_data_o, 32'd0);

      // 2: byte loads with sign / zero extension
      quick_load("lb", 3'b000, 32'h0000_0203, 32'h8011_2233, 32'hFFFF_FF80);
      quick_load("lbu", 3'b100, 32'h0000_0203, 32'h8011_2233, 32'h0000_0080);
      quick_load("lh", 3'b001, 32'h0000_0202, 32'h8011_2233, 32'hFFFF_8011);
      quick_load("lhu", 3'b101, 32'h0000_0200, 32'h8011_A233, 32'h0000_A233);

      // 3: stores
      quick_store("sb", 3'b000, 32'h0000_0302, 32'h0000_00AB, 4'b0100, 32'hABAB_ABAB);
      quick_store("sh", 3'b001, 32'h0000_0302, 32'h0000_1234, 4'b1100, 32'h1234_1234);
      quick_store("sw", 3'b010, 32'h0000_0300, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);

      // 4: single-cycle lw, result held while advance stays low
      pulses = 0;
      drive_op(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0000_0000);
      dmem_bus.dmem_resp  = 1'b1;
      dmem_bus.dmem_rdata = 32'h0BAD_F00D;
      settle();
      if (dmem_bus.dmem_read) pulses++;
      tick();
      dmem_bus.dmem_resp = 1'b0;
      for (int i = 0; i < 2; i++) begin
         settle();
         if (dmem_bus.dmem_read) pulses++;
         check_eq($sformatf("hold_data%0d", i), load_data_o, 32'h0BAD_F00D);
         tick();
      end
      check_eq("hold_pulses", pulses, 32'd1);
      retire();
      settle();
      check_eq("hold_idle_stall", {31'd0, stall_o}, 32'd0);
      check_eq("hold_idle_data", load_data_o, 32'd0);

      // 5: misaligned word load
      drive_op(1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'h0000_0000);
      settle();
      check_eq("mis_read", {31'd0, dmem_bus.dmem_read}, 32'd0);
      check_eq("mis_stall", {31'd0, stall_o}, 32'd1);
      tick();
      settle();
      check_eq("mis_flag", {31'd0, misaligned_o}, 32'd1);
      check_eq("mis_data", load_data_o, 32'd0);
      retire();
      settle();
      check_eq("mis_cleared", {31'd0, misaligned_o}, 32'd0);
      drive_op(1'b0, 1'b1, 3'b001, 32'h0000_0303, 32'h0000_5555);
      settle();
      check_eq("mis_sh_write", {31'd0, dmem_bus.dmem_write}, 32'd0);
      tick();
      settle();
      check_eq("mis_sh_flag", {31'd0, misaligned_o}, 32'd1);
      retire();

      // 6: flush during REQ, drained response is discarded
      drive_op(1'b1, 1'b0, 3'b010, 32'h0000_0500, 32'h0000_0000);
      settle();
      check_eq("fl_issue", {31'd0, dmem_bus.dmem_read}, 32'd1);
      tick();
      flush_i = 1'b1;
      settle();
      check_eq("fl_req_read", {31'd0, dmem_bus.dmem_read}, 32'd1);
      tick();
      clear_inputs();
      alu_out_i = 32'h0000_0FF0;
      settle();
      check_eq("fl_drain_read", {31'd0, dmem_bus.dmem_read}, 32'd1);
      check_eq("fl_drain_addr", dmem_bus.dmem_address, 32'h0000_0500);
      check_eq("fl_drain_stall", {31'd0, stall_o}, 32'd0);
      tick();
      dmem_bus.dmem_resp  = 1'b1;
      dmem_bus.dmem_rdata = 32'h1111_1111;
      settle();
      check_eq("fl_resp_read", {31'd0, dmem_bus.dmem_read}, 32'd1);
      tick();
      dmem_bus.dmem_resp = 1'b0;
      settle();
      check_eq("fl_after_read", {31'd0, dmem_bus.dmem_read}, 32'd0);
      check_eq("fl_after_data", load_data_o, 32'd0);
      quick_load("fl_next", 3'b010, 32'h0000_0600, 32'h2222_2222, 32'h2222_2222);

      // 7: reset while a request is outstanding
      drive_op(1'b1, 1'b0, 3'b010, 32'h0000_0700, 32'h0000_0000);
      tick();
      settle();
      check_eq("rq_read", {31'd0, dmem_bus.dmem_read}, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      clear_inputs();
      settle();
      check_eq("rq_rst_read", {31'd0, dmem_bus.dmem_read}, 32'd0);
      check_eq("rq_rst_write", {31'd0, dmem_bus.dmem_write}, 32'd0);
      check_eq("rq_rst_stall", {31'd0, stall_o}, 32'd0);
      check_eq("rq_rst_data", load_data_o, 32'd0);
      check_eq("rq_rst_mis", {31'd0, misaligned_o}, 32'd0);
      quick_load("rq_next", 3'b010, 32'h0000_0104, 32'h3333_4444, 32'h3333_4444);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_stage_dmem_ctrl.md
Name: mem_stage_dmem_ctrl

Overview:
- MEM-stage data-memory controller; consumes the EX/MEM pipeline register outputs and drives the data-memory request/response port.
- Issues RV32I loads and stores:
  - stores: byte enables and byte-lane replication;
  - loads: sign/zero extension of returned data.
- Stalls the pipeline until the access completes and holds the load result until the pipeline advances into MEM/WB.

Parameters:
- none (RV32I widths fixed by rv32i_types)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- valid_i  in  1  EX/MEM holds a live instruction
- mem_read_i  in  1  control word: instruction is a load
- mem_write_i  in  1  control word: instruction is a store
- funct3_i  in  3  load/store width (lb/lh/lw/lbu/lhu; sb/sh/sw)
- alu_out_i  in  32  effective byte address
- rs2_out_i  in  32  store data
- advance_i  in  1  EX/MEM and MEM/WB load this cycle
- flush_i  in  1  squash the instruction in MEM
- dmem_read  out  1  read request
- dmem_write  out  1  write request
- dmem_mbe  out  4  byte enables
- dmem_address  out  32  word-aligned address {alu_out_i[31:2],2'b00}
- dmem_wdata  out  32  lane-replicated store data
- dmem_resp  in  1  memory completes the request this cycle
- dmem_rdata  in  32  read word, valid with dmem_resp
- load_data_o  out  32  extended load result to MEM/WB
- stall_o  out  1  hold the pipeline
- misaligned_o  out  1  misaligned access detected (held in DONE)

Behaviour:
- Definitions:
  - op = valid_i & (mem_read_i | mem_write_i) & ~flush_i.
  - Misaligned cases:
    - half access with addr[0]=1;
    - word access with addr[1:0]≠0.
- FSM states: IDLE, REQ, DONE, DRAIN.
- IDLE:
  - op & aligned: assert dmem_read/dmem_write combinationally.
    - dmem_resp=1 → DONE.
    - otherwise → REQ.
  - op & misaligned: no request; set misaligned register, load_data=0 → DONE.
  - stall_o = op.
- REQ:
  - Request, address, mbe and wdata held stable until dmem_resp; stall_o=1.
  - On dmem_resp → DONE.
  - flush_i in REQ: request is not abandoned → DRAIN.
- DRAIN:
  - Request held until dmem_resp; response discarded → IDLE.
  - stall_o=0; no DONE state entered.
- DONE:
  - No request; stall_o=0; load_data_o and misaligned_o come from registers.
  - advance_i or flush_i → IDLE, registers cleared.
  - Otherwise hold. This prevents reissue when other stages stall.
- Load data is captured on the dmem_resp cycle:
  - byte = rdata[8*addr[1:0]+:8]; half = rdata[16*addr[1]+:16].
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word.
- Stores:
  - sb: mbe=4'b0001<<addr[1:0]; wdata={4{rs2[7:0]}}.
  - sh: mbe=4'b0011<<{addr[1],1'b0}; wdata={2{rs2[15:0]}}.
  - sw: mbe=4'b1111; wdata=rs2.
  - Loads: mbe=4'b1111.
- Timing:
  - Minimum latency: request in cycle N, resp in N, result in DONE in N+1.
  - Stall is asserted for every request cycle.
- Reset:
  - All outputs 0, state IDLE, load_data/misaligned registers 0.
  - Reset mid-REQ drops the request immediately; the memory is reset concurrently.
- Undefined funct3: treated as word width.

Decomposition:
- rv32i_types holds the load_funct3_t/store_funct3_t enums and a new dmem_state_t enum.
- One natural sub-module: load_align_ext (combinational byte/half select and extension), reusable by the forwarding path.

Test Plan:
1. lw addr 0x100, resp after 3 cycles, rdata 0xDEADBEEF:
   - dmem_read high 3 cycles, address 0x100, stall 3 cycles;
   - then DONE with load_data 0xDEADBEEF.
2. lb / lbu addr 0x203, rdata 0x80112233:
   - lb: load_data 0xFFFFFF80;
   - lbu: 0x00000080.
3. sb / sh / sw stores:
   - sb addr 0x302, rs2 0x000000AB: mbe 0100, wdata 0xABABABAB.
   - sh addr 0x302, rs2 0x1234: mbe 1100, wdata 0x12341234.
   - sw addr 0x300: mbe 1111.
4. Resp in the request cycle, advance_i held low 2 cycles:
   - exactly one request pulse;
   - load_data stable across both cycles;
   - IDLE after advance.
5. lw addr 0x102:
   - no dmem_read, misaligned_o=1 in DONE, load_data 0.
6. Flush during REQ, resp 2 cycles later:
   - request stays asserted until resp, stall drops at flush, data discarded;
   - the next lw issues normally.
7. rst in REQ:
   - dmem_read low the next cycle, all outputs 0.
